// File: rtl/facq_prn_gen_nco_if.sv
// Code-phase slew request channel: the master asks the generator to advance
// the code by slew_chips chips and holds the request until slew_ready.
interface facq_prn_gen_nco_if #(
   parameter int CNTR_SIZE = 14
);
   logic                 slew_valid;
   logic                 slew_ready;
   logic [CNTR_SIZE-1:0] slew_chips;

   modport master (output slew_valid, output slew_chips, input slew_ready);
   modport slave  (input slew_valid, input slew_chips, output slew_ready);
endinterface

// File: rtl/facq_prn_gen_nco.sv
// PRN chip generator for fast acquisition: two Fibonacci LFSRs paced by a
// fractional chip-rate NCO, with overlay code, L5 short reset and code slew.
module facq_prn_gen_nco #(
   parameter int              PRN_SIZE   = 14,
   parameter int              CNTR_SIZE  = 14,
   parameter int              OVL_LEN    = 20,
   parameter int              OVL_W      = 5,
   parameter int              NCO_W      = 24,
   parameter int              L5_W       = 13,
   parameter logic [L5_W-1:0] L5_PATTERN = 13'h1FFD
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 do_init,
   input  logic                 en,
   input  logic [NCO_W:0]       rate_inc,
   input  logic [PRN_SIZE-1:0]  code_state1,
   input  logic [PRN_SIZE-1:0]  code_reset_state1,
   input  logic [PRN_SIZE-1:0]  code_bitmask1,
   input  logic [PRN_SIZE-1:0]  code_out_bitmask1,
   input  logic [PRN_SIZE-1:0]  code_state2,
   input  logic [PRN_SIZE-1:0]  code_reset_state2,
   input  logic [PRN_SIZE-1:0]  code_bitmask2,
   input  logic [PRN_SIZE-1:0]  code_out_bitmask2,
   input  logic [CNTR_SIZE-1:0] prn_length,
   input  logic [CNTR_SIZE-1:0] prn_init,
   input  logic                 gps_l5_reset_en,
   input  logic                 single_sr,
   input  logic [OVL_LEN-1:0]   ovl,
   input  logic [OVL_W-1:0]     ovl_length,
   input  logic [OVL_W-1:0]     ovl_init,
   facq_prn_gen_nco_if.slave    slew,
   output logic                 chip_out,
   output logic                 chip_valid,
   output logic                 epoch,
   output logic [PRN_SIZE-1:0]  sr1,
   output logic [PRN_SIZE-1:0]  sr2,
   output logic [CNTR_SIZE-1:0] prn_counter,
   output logic [OVL_W-1:0]     ovl_cntr
);

   typedef enum logic {IDLE, SLEW} state_t;

   localparam logic [NCO_W:0] ONE_CHIP = {1'b1, {NCO_W{1'b0}}};

   state_t               state, state_nxt;
   logic [NCO_W-1:0]     acc;
   logic [NCO_W:0]       rate_sat, acc_sum;
   logic [CNTR_SIZE-1:0] rem, rem_nxt;
   logic                 nco_shift, do_shift, wrap, x2, fb1, fb2, l5_hit, ovl_wrap;

   // Rates above one chip per clock saturate so the carry never skips a chip.
   assign rate_sat  = (rate_inc > ONE_CHIP) ? ONE_CHIP : rate_inc;
   assign acc_sum   = {1'b0, acc} + rate_sat;
   assign nco_shift = (state == IDLE) && en && acc_sum[NCO_W];
   assign do_shift  = nco_shift || (state == SLEW);

   assign slew.slew_ready = (state == IDLE) && !do_init && !reset;

   assign wrap     = (prn_counter == prn_length);
   assign x2       = ^(code_bitmask2 & sr2);
   assign fb1      = (^(code_bitmask1 & sr1)) ^ (single_sr & x2);
   assign fb2      = single_sr ? sr1[PRN_SIZE-1] : x2;
   assign l5_hit   = gps_l5_reset_en && (sr1[L5_W-1:0] == L5_PATTERN);
   assign ovl_wrap = (ovl_cntr == ovl_length) || (ovl_cntr == OVL_W'(OVL_LEN-1));

   assign chip_out = (^(code_out_bitmask1 & sr1)) ^ (^(code_out_bitmask2 & sr2)) ^ ovl[ovl_cntr];

   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      case (state)
         IDLE: if (slew.slew_valid && slew.slew_ready && (slew.slew_chips != '0)) begin
            state_nxt = SLEW;
            rem_nxt   = slew.slew_chips;
         end
         SLEW: begin
            rem_nxt = rem - CNTR_SIZE'(1);
            if (rem == CNTR_SIZE'(1)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         acc         <= '0;
         rem         <= '0;
         sr1         <= '0;
         sr2         <= '0;
         prn_counter <= '0;
         ovl_cntr    <= '0;
         chip_valid  <= 1'b0;
         epoch       <= 1'b0;
      end else if (do_init) begin
         state       <= IDLE;
         acc         <= '0;
         rem         <= '0;
         sr1         <= code_state1;
         sr2         <= code_state2;
         prn_counter <= prn_init;
         ovl_cntr    <= ovl_init;
         chip_valid  <= 1'b0;
         epoch       <= 1'b0;
      end else begin
         state <= state_nxt;
         rem   <= rem_nxt;
         // Accumulator is frozen while slewing so the chip phase resumes cleanly.
         if (state == IDLE && en) acc <= acc_sum[NCO_W-1:0];
         chip_valid <= nco_shift;
         epoch      <= nco_shift && wrap;
         if (do_shift) begin
            prn_counter <= wrap ? '0 : prn_counter + CNTR_SIZE'(1);
            if (wrap || l5_hit) sr1 <= code_reset_state1;
            else                sr1 <= {sr1[PRN_SIZE-2:0], fb1};
            sr2 <= wrap ? code_reset_state2 : {sr2[PRN_SIZE-2:0], fb2};
            if (wrap) ovl_cntr <= ovl_wrap ? '0 : ovl_cntr + OVL_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_facq_prn_gen_nco.sv
// Directed bench for facq_prn_gen_nco: cycle vector table plus hand-written
// sequences for period wrap, half rate, overlay, L5 reset, single-SR and abort.
module tb_facq_prn_gen_nco;

   localparam logic [24:0] R1 = 25'h1000000;  // one chip per clock
   localparam logic [24:0] RH = 25'h0800000;  // half rate

   logic        clk, reset, do_init, en;
   logic [24:0] rate_inc;
   logic [13:0] cs1, crs1, cb1, cob1, cs2, crs2, cb2, cob2;
   logic [13:0] prn_length, prn_init;
   logic        l5_en, single_sr;
   logic [19:0] ovl;
   logic [4:0]  ovl_length, ovl_init;
   logic        chip_out, chip_valid, epoch;
   logic [13:0] sr1, sr2, prn_counter;
   logic [4:0]  ovl_cntr;

   facq_prn_gen_nco_if #(.CNTR_SIZE(14)) sif ();

   facq_prn_gen_nco dut (
      .clk(clk), .reset(reset), .do_init(do_init), .en(en), .rate_inc(rate_inc),
      .code_state1(cs1), .code_reset_state1(crs1), .code_bitmask1(cb1), .code_out_bitmask1(cob1),
      .code_state2(cs2), .code_reset_state2(crs2), .code_bitmask2(cb2), .code_out_bitmask2(cob2),
      .prn_length(prn_length), .prn_init(prn_init), .gps_l5_reset_en(l5_en), .single_sr(single_sr),
      .ovl(ovl), .ovl_length(ovl_length), .ovl_init(ovl_init), .slew(sif.slave),
      .chip_out(chip_out), .chip_valid(chip_valid), .epoch(epoch), .sr1(sr1), .sr2(sr2),
      .prn_counter(prn_counter), .ovl_cntr(ovl_cntr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   logic refc [1023];

   typedef struct {
      logic        en;
      logic [24:0] rate;
      logic        sv;
      logic [13:0] sc;
      logic        cv, ep;
      logic [13:0] cnt;
      logic        chip, rdy;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // 10-bit x^10+x^3+1 code in the low bits of the 14-bit registers.
   task automatic cfg_base();
      cs1 = 14'h03FF; crs1 = 14'h03FF; cb1 = 14'h0204; cob1 = 14'h0200;
      cs2 = '0; crs2 = '0; cb2 = '0; cob2 = '0;
      prn_length = 14'd1022; prn_init = '0; l5_en = 1'b0; single_sr = 1'b0;
      ovl = '0; ovl_length = '0; ovl_init = '0;
   endtask

   task automatic init_pulse();
      en = 1'b0; sif.slew_valid = 1'b0; do_init = 1'b1;
      step();
      do_init = 1'b0;
      #1;
   endtask

   initial begin
      logic [9:0] s;
      s = 10'h3FF;
      for (int k = 0; k < 1023; k++) begin
         refc[k] = s[9];
         s = {s[8:0], s[9] ^ s[2]};
      end

      //            en  rate          sv  sc      cv ep cnt     chip rdy
      vecs[0]  = '{1'b0, 25'h0,       1'b0, 14'd0, 1'b0, 1'b0, 14'd0,  1'b1, 1'b1};
      vecs[1]  = '{1'b1, R1,          1'b0, 14'd0, 1'b1, 1'b0, 14'd1,  1'b1, 1'b1};
      vecs[2]  = '{1'b1, RH,          1'b0, 14'd0, 1'b0, 1'b0, 14'd1,  1'b1, 1'b1};
      vecs[3]  = '{1'b1, RH,          1'b0, 14'd0, 1'b1, 1'b0, 14'd2,  1'b1, 1'b1};
      vecs[4]  = '{1'b1, 25'h1FFFFFF, 1'b0, 14'd0, 1'b1, 1'b0, 14'd3,  1'b1, 1'b1};
      vecs[5]  = '{1'b0, R1,          1'b0, 14'd0, 1'b0, 1'b0, 14'd3,  1'b1, 1'b1};
      vecs[6]  = '{1'b1, 25'h0,       1'b0, 14'd0, 1'b0, 1'b0, 14'd3,  1'b1, 1'b1};
      vecs[7]  = '{1'b1, R1,          1'b1, 14'd5, 1'b1, 1'b0, 14'd4,  1'b1, 1'b0};
      vecs[8]  = '{1'b1, R1,          1'b0, 14'd0, 1'b0, 1'b0, 14'd5,  1'b1, 1'b0};
      vecs[9]  = '{1'b1, R1,          1'b1, 14'd3, 1'b0, 1'b0, 14'd6,  1'b1, 1'b0};
      vecs[10] = '{1'b1, R1,          1'b0, 14'd0, 1'b0, 1'b0, 14'd7,  1'b1, 1'b0};
      vecs[11] = '{1'b1, R1,          1'b0, 14'd0, 1'b0, 1'b0, 14'd8,  1'b1, 1'b0};
      vecs[12] = '{1'b1, R1,          1'b0, 14'd0, 1'b0, 1'b0, 14'd9,  1'b1, 1'b1};
      vecs[13] = '{1'b1, R1,          1'b0, 14'd0, 1'b1, 1'b0, 14'd10, 1'b0, 1'b1};
      vecs[14] = '{1'b0, 25'h0,       1'b1, 14'd0, 1'b0, 1'b0, 14'd10, 1'b0, 1'b1};
      vecs[15] = '{1'b0, 25'h0,       1'b0, 14'd0, 1'b0, 1'b0, 14'd10, 1'b0, 1'b1};

      reset = 1'b1; do_init = 1'b0; en = 1'b0; rate_inc = '0;
      sif.slew_valid = 1'b0; sif.slew_chips = '0;
      cfg_base();
      step(); step();
      chk("rst_sr1", 32'(sr1), 32'h0);
      chk("rst_cnt", 32'(prn_counter), 32'h0);
      chk("rst_cv", 32'(chip_valid), 32'h0);
      chk("rst_rdy", 32'(sif.slew_ready), 32'h0);
      reset = 1'b0;

      // Cycle-by-cycle table: NCO rates, saturation, hold, slew accept/ignore.
      init_pulse();
      for (int i = 0; i < 16; i++) begin
         en = vecs[i].en; rate_inc = vecs[i].rate;
         sif.slew_valid = vecs[i].sv; sif.slew_chips = vecs[i].sc;
         step();
         chk($sformatf("v%0d_cv", i),   32'(chip_valid),     32'(vecs[i].cv));
         chk($sformatf("v%0d_ep", i),   32'(epoch),          32'(vecs[i].ep));
         chk($sformatf("v%0d_cnt", i),  32'(prn_counter),    32'(vecs[i].cnt));
         chk($sformatf("v%0d_chip", i), 32'(chip_out),       32'(vecs[i].chip));
         chk($sformatf("v%0d_rdy", i),  32'(sif.slew_ready), 32'(vecs[i].rdy));
      end
      sif.slew_valid = 1'b0;

      // Full rate over two periods: sequence, epoch and counter wrap.
      cfg_base(); init_pulse();
      chk("full_chip0", 32'(chip_out), 32'(refc[0]));
      en = 1'b1; rate_inc = R1;
      for (int k = 1; k <= 2046; k++) begin
         step();
         chk("full_cv", 32'(chip_valid), 32'h1);
         chk("full_chip", 32'(chip_out), 32'(refc[k % 1023]));
         chk("full_ep", 32'(epoch), 32'((k % 1023) == 0));
      end
      chk("full_cnt_end", 32'(prn_counter), 32'h0);

      // Half rate: first chip_valid two cycles after en rises.
      cfg_base(); init_pulse();
      en = 1'b1; rate_inc = RH;
      for (int c = 1; c <= 40; c++) begin
         step();
         chk("half_cv", 32'(chip_valid), 32'((c % 2) == 0));
         if (chip_valid) chk("half_chip", 32'(chip_out), 32'(refc[c / 2]));
      end

      // Overlay: 16-chip period, alternate periods inverted.
      cfg_base(); prn_length = 14'd15; ovl = 20'h00002; ovl_length = 5'd1; ovl_init = 5'd0;
      init_pulse();
      en = 1'b1; rate_inc = R1;
      for (int k = 1; k <= 64; k++) begin
         step();
         chk("ovl_chip", 32'(chip_out), 32'(refc[k % 16] ^ ((k / 16) % 2)));
         chk("ovl_cntr", 32'(ovl_cntr), 32'((k / 16) % 2));
      end

      // L5 short reset: first shift lands on the pattern, second reloads sr1.
      cfg_base(); cs1 = 14'h0FFE; crs1 = 14'h1234; cb1 = 14'h0002; cob1 = '0;
      cs2 = 14'h0001; prn_init = 14'd5; prn_length = 14'd1000; l5_en = 1'b1;
      init_pulse();
      en = 1'b1; rate_inc = R1;
      step();
      chk("l5_sr1_a", 32'(sr1), 32'h1FFD);
      chk("l5_sr2_a", 32'(sr2), 32'h0002);
      step();
      chk("l5_sr1_b", 32'(sr1), 32'h1234);
      chk("l5_sr2_b", 32'(sr2), 32'h0004);
      chk("l5_cnt_b", 32'(prn_counter), 32'd7);
      l5_en = 1'b0;
      init_pulse();
      en = 1'b1;
      step(); step();
      chk("l5off_sr1", 32'(sr1), 32'h3FFA);

      // Single-SR: SR2 fed from SR1 MSB, SR2 taps folded into SR1 feedback.
      cfg_base(); cs1 = 14'h2000; cs2 = 14'h0001; cb1 = '0; cb2 = 14'h0001; single_sr = 1'b1;
      init_pulse();
      en = 1'b1; rate_inc = R1;
      step();
      chk("ssr_sr1", 32'(sr1), 32'h0001);
      chk("ssr_sr2", 32'(sr2), 32'h0003);

      // Abort a long slew with do_init, then reset mid-run.
      cfg_base(); init_pulse();
      en = 1'b1; rate_inc = R1; sif.slew_valid = 1'b1; sif.slew_chips = 14'd100;
      step();
      sif.slew_valid = 1'b0;
      step(); step();
      chk("abort_rdy_mid", 32'(sif.slew_ready), 32'h0);
      cs1 = 14'h0155; cs2 = 14'h02AA; prn_init = 14'd7; ovl_init = 5'd3; ovl_length = 5'd5;
      do_init = 1'b1;
      step();
      do_init = 1'b0; en = 1'b0;
      #1;
      chk("abort_rdy", 32'(sif.slew_ready), 32'h1);
      chk("abort_sr1", 32'(sr1), 32'h0155);
      chk("abort_sr2", 32'(sr2), 32'h02AA);
      chk("abort_cnt", 32'(prn_counter), 32'd7);
      chk("abort_ovl", 32'(ovl_cntr), 32'd3);
      chk("abort_cv", 32'(chip_valid), 32'h0);
      step();
      chk("abort_hold_cnt", 32'(prn_counter), 32'd7);
      en = 1'b1;
      step(); step(); step();
      ovl = 20'h00001; reset = 1'b1;
      step();
      chk("rst2_sr1", 32'(sr1), 32'h0);
      chk("rst2_sr2", 32'(sr2), 32'h0);
      chk("rst2_cnt", 32'(prn_counter), 32'h0);
      chk("rst2_ovl", 32'(ovl_cntr), 32'h0);
      chk("rst2_cv", 32'(chip_valid), 32'h0);
      chk("rst2_ep", 32'(epoch), 32'h0);
      chk("rst2_rdy", 32'(sif.slew_ready), 32'h0);
      chk("rst2_chip", 32'(chip_out), 32'h1);
      reset = 1'b0; en = 1'b0;
      #1;
      chk("rst2_rdy_rel", 32'(sif.slew_ready), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
